// File: rtl/io_pkg.sv
// Shared register-map constants and decode helpers for the memory-mapped IO window.
package io_pkg;

    // Each port owns a pair of addresses: IN at the even slot, OUT at the odd slot.
    localparam int PORT_STRIDE = 2;
    localparam int IN_OFF      = 0;
    localparam int OUT_OFF     = 1;
    // STATUS and MASK sit right after the port pairs, relative to 2*NUM_PORTS.
    localparam int STATUS_OFF  = 0;
    localparam int MASK_OFF    = 1;

    typedef enum logic [2:0] {
        RK_NONE,
        RK_IN,
        RK_OUT,
        RK_STATUS,
        RK_MASK
    } reg_kind_e;

    // Number of addresses claimed by the IO window at the top of the address space.
    function automatic int io_span(input int num_ports);
        return PORT_STRIDE * num_ports + 2;
    endfunction

    // First address of the IO window.
    function automatic int io_base(input int addr_w, input int num_ports);
        return (1 << addr_w) - io_span(num_ports);
    endfunction

    // Classify a window offset; anything past the window decodes to RK_NONE.
    function automatic reg_kind_e reg_kind(input int off, input int num_ports);
        reg_kind_e k;
        k = RK_NONE;
        if (off >= 0 && off < PORT_STRIDE * num_ports)
            k = ((off % PORT_STRIDE) == IN_OFF) ? RK_IN : RK_OUT;
        else if (off == PORT_STRIDE * num_ports + STATUS_OFF)
            k = RK_STATUS;
        else if (off == PORT_STRIDE * num_ports + MASK_OFF)
            k = RK_MASK;
        return k;
    endfunction

endpackage

// File: rtl/io_sync.sv
// One input port: multi-stage synchroniser with change detection on the synchronised value.
module io_sync #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] q,
    output logic              chg
);

    localparam int CW = $clog2(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][DATA_W-1:0] stg;
    logic [CW-1:0]                      fill_cnt;
    logic                               armed;

    // Shift the asynchronous input through the chain; count edges until the chain holds real data.
    always_ff @(negedge clk) begin
        if (rst) begin
            stg      <= '0;
            fill_cnt <= '0;
        end else begin
            stg <= {stg[SYNC_STAGES-2:0], din};
            if (fill_cnt != CW'(SYNC_STAGES))
                fill_cnt <= fill_cnt + 1'b1;
        end
    end

    // Values arriving while the chain refills after reset are not treated as changes.
    assign armed = (fill_cnt == CW'(SYNC_STAGES));
    assign q     = stg[SYNC_STAGES-1];
    // High when the next edge will move q to a different value.
    assign chg   = armed && (stg[SYNC_STAGES-2] != stg[SYNC_STAGES-1]);

endmodule

// File: rtl/io_ports.sv
// Memory-mapped IO port block occupying the top of the address space; lower addresses go to RAM.
module io_ports
    import io_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 10,
    parameter int NUM_PORTS   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en_store,
    input  logic [ADDR_W-1:0]           addr_store,
    input  logic [DATA_W-1:0]           data_store,
    input  logic                        en_load,
    input  logic [ADDR_W-1:0]           addr_load,
    output logic [DATA_W-1:0]           data_load,
    input  logic [NUM_PORTS*DATA_W-1:0] io_input,
    output logic [NUM_PORTS*DATA_W-1:0] io_output,
    output logic [NUM_PORTS-1:0]        io_out_stb,
    output logic                        irq,
    output logic                        mem_en_load,
    output logic                        mem_en_store
);

    localparam int                PW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(io_base(ADDR_W, NUM_PORTS));

    logic [NUM_PORTS-1:0][DATA_W-1:0] in_q;
    logic [NUM_PORTS-1:0][DATA_W-1:0] out_q;
    logic [NUM_PORTS-1:0]             chg;
    logic [NUM_PORTS-1:0]             status_q;
    logic [NUM_PORTS-1:0]             mask_q;
    logic [NUM_PORTS-1:0]             stb_q;
    logic                             irq_q;

    logic              ld_win, st_win;
    logic [ADDR_W-1:0] ld_off, st_off;
    logic [PW-1:0]     ld_idx, st_idx;
    reg_kind_e         ld_kind, st_kind;
    logic [DATA_W-1:0] rd_val;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        io_sync #(
            .DATA_W      (DATA_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk (clk),
            .rst (rst),
            .din (io_input[gi*DATA_W +: DATA_W]),
            .q   (in_q[gi]),
            .chg (chg[gi])
        );
        assign io_output[gi*DATA_W +: DATA_W] = out_q[gi];
    end

    // Address decode: window hit, offset into the window and port index for both access paths.
    assign ld_win  = (addr_load  >= BASE_A);
    assign st_win  = (addr_store >= BASE_A);
    assign ld_off  = addr_load  - BASE_A;
    assign st_off  = addr_store - BASE_A;
    assign ld_idx  = PW'(ld_off >> 1);
    assign st_idx  = PW'(st_off >> 1);
    assign ld_kind = (en_load  && ld_win) ? reg_kind(int'(ld_off), NUM_PORTS) : RK_NONE;
    assign st_kind = (en_store && st_win) ? reg_kind(int'(st_off), NUM_PORTS) : RK_NONE;

    assign mem_en_load  = en_load  && !ld_win;
    assign mem_en_store = en_store && !st_win;

    // Read mux over the current (pre-edge) register values.
    always_comb begin
        rd_val = '0;
        case (ld_kind)
            RK_IN:     rd_val = in_q[ld_idx];
            RK_OUT:    rd_val = out_q[ld_idx];
            RK_STATUS: rd_val = DATA_W'(status_q);
            RK_MASK:   rd_val = DATA_W'(mask_q);
            default:   rd_val = '0;
        endcase
    end

    assign data_load = (en_load && ld_win) ? rd_val : 'z;

    // Register file update: stores, strobes, sticky status with read-to-clear, registered irq.
    always_ff @(negedge clk) begin
        if (rst) begin
            out_q    <= '0;
            status_q <= '0;
            mask_q   <= '0;
            stb_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            stb_q <= '0;
            if (st_kind == RK_OUT) begin
                out_q[st_idx] <= data_store;
                stb_q[st_idx] <= 1'b1;
            end
            if (st_kind == RK_MASK)
                mask_q <= data_store[NUM_PORTS-1:0];
            // A bit that sets on the same edge as a clearing read survives.
            if (ld_kind == RK_STATUS)
                status_q <= chg;
            else
                status_q <= status_q | chg;
            irq_q <= |(status_q & mask_q);
        end
    end

    assign io_out_stb = stb_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_io_ports.sv
// Self-checking bench for io_ports: directed scenarios plus randomized traffic against a queue-based model.
module tb_io_ports;

    localparam int DW   = 8;
    localparam int AW   = 10;
    localparam int NP   = 2;
    localparam int SS   = 2;
    localparam int BASE = (1 << AW) - (2 * NP + 2);

    logic              clk;
    logic              rst;
    logic              en_store, en_load;
    logic [AW-1:0]     addr_store, addr_load;
    logic [DW-1:0]     data_store;
    logic [DW-1:0]     data_load;
    logic [NP*DW-1:0]  io_input, io_output;
    logic [NP-1:0]     io_out_stb;
    logic              irq, mem_en_load, mem_en_store;

    int n_chk = 0;
    int n_err = 0;

    // Model state
    logic [DW-1:0]    m_out [NP];
    logic [NP-1:0]    m_status, m_mask, m_stb;
    logic             m_irq;
    logic [NP*DW-1:0] hist [$];
    int               edges_since_rst;

    // Last sampled DUT outputs
    logic [DW-1:0]    obs_dl;
    logic [NP*DW-1:0] obs_out;
    logic [NP-1:0]    obs_stb;
    logic             obs_irq, obs_mel, obs_mes;

    io_ports #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .NUM_PORTS   (NP),
        .SYNC_STAGES (SS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en_store     (en_store),
        .addr_store   (addr_store),
        .data_store   (data_store),
        .en_load      (en_load),
        .addr_load    (addr_load),
        .data_load    (data_load),
        .io_input     (io_input),
        .io_output    (io_output),
        .io_out_stb   (io_out_stb),
        .irq          (irq),
        .mem_en_load  (mem_en_load),
        .mem_en_store (mem_en_store)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // IN[k] is whatever port k held SS edges ago (zero until SS edges since reset).
    function automatic logic [DW-1:0] m_in(input int k);
        logic [NP*DW-1:0] v;
        if (hist.size() < SS) return '0;
        v = hist[hist.size() - SS];
        return v[k*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] exp_dl();
        int off;
        logic [DW-1:0] r;
        r = 'z;
        if (en_load && int'(addr_load) >= BASE) begin
            off = int'(addr_load) - BASE;
            if (off < 2 * NP)
                r = (off % 2 == 0) ? m_in(off / 2) : m_out[off / 2];
            else if (off == 2 * NP)
                r = DW'(m_status);
            else
                r = DW'(m_mask);
        end
        return r;
    endfunction

    // Advance the model by one falling edge using the inputs present before it.
    task automatic model_step();
        logic [DW-1:0] old_in [NP];
        logic [NP-1:0] set_b, stb_n, mask_n;
        logic          irq_n;
        int            nb, off;
        if (rst) begin
            for (int k = 0; k < NP; k++) m_out[k] = '0;
            m_status = '0; m_mask = '0; m_stb = '0; m_irq = 1'b0;
            hist.delete();
            edges_since_rst = 0;
        end else begin
            for (int k = 0; k < NP; k++) old_in[k] = m_in(k);
            nb = edges_since_rst;
            hist.push_back(io_input);
            while (hist.size() > SS + 1) void'(hist.pop_front());
            edges_since_rst++;
            set_b = '0;
            for (int k = 0; k < NP; k++)
                if (nb >= SS && m_in(k) != old_in[k]) set_b[k] = 1'b1;
            irq_n  = |(m_status & m_mask);
            stb_n  = '0;
            mask_n = m_mask;
            if (en_store && int'(addr_store) >= BASE) begin
                off = int'(addr_store) - BASE;
                if (off < 2 * NP && off % 2 == 1) begin
                    m_out[off / 2] = data_store;
                    stb_n[off / 2] = 1'b1;
                end else if (off == 2 * NP + 1) begin
                    mask_n = data_store[NP-1:0];
                end
            end
            if (en_load && int'(addr_load) == BASE + 2 * NP)
                m_status = set_b;
            else
                m_status = m_status | set_b;
            m_mask = mask_n;
            m_stb  = stb_n;
            m_irq  = irq_n;
        end
    endtask

    // Check all outputs mid-cycle, then let one falling edge happen.
    task automatic tick();
        logic [NP*DW-1:0] eo;
        @(posedge clk);
        #1;
        obs_dl  = data_load;
        obs_out = io_output;
        obs_stb = io_out_stb;
        obs_irq = irq;
        obs_mel = mem_en_load;
        obs_mes = mem_en_store;
        for (int k = 0; k < NP; k++) eo[k*DW +: DW] = m_out[k];
        chk("data_load",    64'(obs_dl),  64'(exp_dl()));
        chk("mem_en_load",  64'(obs_mel), 64'(en_load  && int'(addr_load)  < BASE));
        chk("mem_en_store", 64'(obs_mes), 64'(en_store && int'(addr_store) < BASE));
        chk("io_output",    64'(obs_out), 64'(eo));
        chk("io_out_stb",   64'(obs_stb), 64'(m_stb));
        chk("irq",          64'(obs_irq), 64'(m_irq));
        @(negedge clk);
        model_step();
        #1;
    endtask

    initial begin
        logic [DW-1:0] zz;
        zz = 'z;
        for (int k = 0; k < NP; k++) m_out[k] = '0;
        m_status = '0; m_mask = '0; m_stb = '0; m_irq = 1'b0;
        edges_since_rst = 0;
        rst = 1'b1; en_store = 1'b0; en_load = 1'b0;
        addr_store = '0; addr_load = '0; data_store = '0;
        io_input = NP*DW'($urandom);

        // Reset with decode still live
        repeat (3) begin
            en_load = 1'b1; addr_load = AW'($urandom);
            tick();
        end
        addr_load = AW'(BASE + 1);
        tick();
        chk("rst_out0_read", 64'(obs_dl), 64'(0));

        // Nonzero inputs at reset release must not set STATUS
        rst = 1'b0; en_load = 1'b0; io_input = 16'h3412;
        repeat (5) tick();
        en_load = 1'b1; addr_load = AW'(BASE + 4);
        tick();
        chk("fill_no_status", 64'(obs_dl), 64'(0));

        // Port0 = 0x5A visible on the 2nd edge, sets STATUS[0]
        en_load = 1'b0; io_input = '0;
        repeat (4) tick();
        en_load = 1'b1; addr_load = AW'(BASE + 4);
        tick();
        io_input = 16'h005A; addr_load = AW'(BASE);
        tick();
        chk("in0_before_e1", 64'(obs_dl), 64'(0));
        tick();
        chk("in0_before_e2", 64'(obs_dl), 64'(0));
        tick();
        chk("in0_after_e2", 64'(obs_dl), 64'h5A);
        addr_load = AW'(BASE + 4);
        tick();
        chk("status_p0", 64'(obs_dl), 64'h01);

        // Store to OUT0
        en_load = 1'b0; en_store = 1'b1; addr_store = AW'(BASE + 1); data_store = 8'hC3;
        tick();
        chk("out0_mem_en_store", 64'(obs_mes), 64'(0));
        en_store = 1'b0;
        tick();
        chk("out0_value", 64'(obs_out[7:0]), 64'hC3);
        chk("out0_stb", 64'(obs_stb), 64'(2'b01));
        tick();
        chk("out0_stb_gone", 64'(obs_stb), 64'(0));

        // MASK = 2, port1 change raises irq one edge after STATUS[1]
        en_store = 1'b1; addr_store = AW'(BASE + 5); data_store = 8'h02;
        tick();
        en_store = 1'b0; io_input[15:8] = 8'h77;
        tick();
        tick();
        tick();
        chk("irq_lags_status", 64'(obs_irq), 64'(0));
        en_load = 1'b1; addr_load = AW'(BASE + 4);
        tick();
        chk("irq_high", 64'(obs_irq), 64'(1));
        chk("status_p1", 64'(obs_dl), 64'h02);
        en_load = 1'b0;
        tick();
        chk("irq_still_high", 64'(obs_irq), 64'(1));
        tick();
        chk("irq_fell", 64'(obs_irq), 64'(0));

        // Port0 change lands on the same edge as a STATUS read
        io_input[7:0] = 8'hA5;
        tick();
        en_load = 1'b1; addr_load = AW'(BASE + 4);
        tick();
        chk("race_read_old", 64'(obs_dl), 64'(0));
        tick();
        chk("race_set_wins", 64'(obs_dl), 64'h01);

        // Just below the window goes to RAM
        en_load = 1'b1; addr_load = AW'(BASE - 1);
        en_store = 1'b1; addr_store = AW'(BASE - 1); data_store = 8'h11;
        tick();
        chk("below_mel", 64'(obs_mel), 64'(1));
        chk("below_mes", 64'(obs_mes), 64'(1));
        chk("below_dl_z", 64'(obs_dl), 64'(zz));

        // Reset mid-operation with OUT0 = 0xFF and irq high
        en_load = 1'b0; addr_store = AW'(BASE + 1); data_store = 8'hFF;
        io_input[15:8] = 8'h00;
        tick();
        en_store = 1'b0;
        tick();
        chk("out0_ff", 64'(obs_out[7:0]), 64'hFF);
        tick();
        tick();
        chk("irq_before_rst", 64'(obs_irq), 64'(1));
        rst = 1'b1; en_store = 1'b1; addr_store = AW'(BASE + 3); data_store = 8'h44;
        tick();
        en_store = 1'b0;
        tick();
        chk("rst_out", 64'(obs_out), 64'(0));
        chk("rst_stb", 64'(obs_stb), 64'(0));
        chk("rst_irq", 64'(obs_irq), 64'(0));
        rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            en_load  = $urandom_range(0, 1) == 1;
            en_store = $urandom_range(0, 2) == 0;
            addr_load  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(BASE - 2, (1 << AW) - 1));
            addr_store = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(BASE - 2, (1 << AW) - 1));
            data_store = DW'($urandom);
            if ($urandom_range(0, 7) == 0) io_input = NP*DW'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
